// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider (signed/unsigned), one quotient bit per clock.
// Latency: done is high 33 clocks after start is accepted (WIDTH+1 for general WIDTH).
//   Throughput is one divide per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE. A start while busy or in FIX is dropped, not queued.
//
// Ports:
//   clk            rising-edge clock
//   clr            asynchronous active-low reset
//   start/sgn/A/B  request, signed mode, dividend, divisor (captured on accepted start)
//   ZLO/ZHI        registered quotient / remainder, held until the next result
//   busy/done      busy from accepted start until the result cycle; done is a one-cycle pulse
//   dz             divide-by-zero flag, present only when DIV_ZERO_FLAG_EN is defined
// Optional feature macro: DIV_ZERO_FLAG_EN (B==0 short-circuits to a 1-clock result with dz).
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ZHI,
  output logic [WIDTH-1:0] ZLO,
  output logic             busy,
`ifdef DIV_ZERO_FLAG_EN
  output logic             done,
  output logic             dz
`else
  output logic             done
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q, quo_q, bmag_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q, rneg_q;
`ifdef DIV_ZERO_FLAG_EN
  logic [WIDTH-1:0] a_q;
  logic             dzero_q;
`endif

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_d, quo_d;

  // Magnitudes. -MIN_INT wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign a_neg = sgn & A[WIDTH-1];
  assign b_neg = sgn & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // {rem,quo} shifted left by one. The partial remainder needs WIDTH+1 bits here
  // because 2*rem+1 can exceed WIDTH bits when |B| is large; after the trial
  // subtract (or restore) it is always < |B| and fits back into WIDTH bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, bmag_q});
  assign rem_d   = ge ? (shifted[WIDTH-1:0] - bmag_q) : shifted[WIDTH-1:0];
  assign quo_d   = {quo_q[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      bmag_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ZHI     <= '0;
      ZLO     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      a_q     <= '0;
      dzero_q <= 1'b0;
      dz      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q  <= '0;
            quo_q  <= a_mag;
            bmag_q <= b_mag;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt_q  <= CW'(WIDTH - 1);
            busy   <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            a_q     <= A;
            dzero_q <= (B == '0);
            state_q <= (B == '0) ? S_FIX : S_ITER;
`else
            state_q <= S_ITER;
`endif
          end
        end
        S_ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          ZLO <= qneg_q ? -quo_q : quo_q;
          ZHI <= rneg_q ? -rem_q : rem_q;
`ifdef DIV_ZERO_FLAG_EN
          // Divide-by-zero bypasses the iterations; report all-ones and the raw dividend.
          if (dzero_q) begin
            ZLO <= '1;
            ZHI <= a_q;
            dz  <= 1'b1;
          end
`endif
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven directed test for seq_divider (WIDTH=32).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_seq_divider;

  logic        clk;
  logic        clr;
  logic        start;
  logic        sgn;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ZHI;
  logic [31:0] ZLO;
  logic        busy;
  logic        done;
`ifdef DIV_ZERO_FLAG_EN
  logic        dz;
`endif

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .sgn   (sgn),
    .A     (A),
    .B     (B),
    .ZHI   (ZHI),
    .ZLO   (ZLO),
    .busy  (busy),
`ifdef DIV_ZERO_FLAG_EN
    .done  (done),
    .dz    (dz)
`else
    .done  (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] exp_zlo;
    logic [31:0] exp_zhi;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one divide and wait (bounded) for done. lat counts edges after the accepting edge.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic busy_at_done,
                         output logic dz_at_done, output logic done_next);
    @(negedge clk);
    A = a; B = b; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    busy_at_done = busy;
`ifdef DIV_ZERO_FLAG_EN
    dz_at_done = dz;
`else
    dz_at_done = 1'b0;
`endif
    @(posedge clk); #1;
    done_next = done;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[13];
    int          lat;
    int          exp_lat;
    logic        bz, dzv, dn;
    logic [31:0] a_hist[102];
    logic [31:0] b_hist[102];
    logic        seen_done;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1]  = '{32'hFFFFFFF9,   32'h2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1};
    vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0};
    vecs[4]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0};
    vecs[5]  = '{32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5};
    vecs[6]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF};
    vecs[7]  = '{32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1};
`ifdef DIV_ZERO_FLAG_EN
    vecs[8]  = '{32'hFFFFFFF7,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF7};
`else
    vecs[8]  = '{32'hFFFFFFF7,   32'd0,          1'b1, 32'h00000001,   32'hFFFFFFF7};
`endif
    vecs[9]  = '{32'd9,          32'd4,          1'b0, 32'd2,          32'd1};
    vecs[10] = '{32'h12345678,   32'h10,         1'b0, 32'h01234567,   32'd8};
    vecs[11] = '{32'h80000000,   32'd2,          1'b1, 32'hC0000000,   32'd0};
    vecs[12] = '{32'h80000000,   32'h80000000,   1'b0, 32'd1,          32'd0};

    clr = 1'b0; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
    #12;
    check("reset_zlo",  {32'd0, ZLO}, 64'd0);
    check("reset_zhi",  {32'd0, ZHI}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset_dz",   {63'd0, dz}, 64'd0);
`endif
    @(negedge clk);
    clr = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].s, lat, bz, dzv, dn);
`ifdef DIV_ZERO_FLAG_EN
      exp_lat = (vecs[i].b == 32'd0) ? 1 : 33;
      check($sformatf("v%0d_dz", i), {63'd0, dzv}, {63'd0, (vecs[i].b == 32'd0)});
`else
      exp_lat = 33;
`endif
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
      check($sformatf("v%0d_zlo", i), {32'd0, ZLO}, {32'd0, vecs[i].exp_zlo});
      check($sformatf("v%0d_zhi", i), {32'd0, ZHI}, {32'd0, vecs[i].exp_zhi});
      check($sformatf("v%0d_busy_at_done", i), {63'd0, bz}, 64'd0);
      check($sformatf("v%0d_done_one_cycle", i), {63'd0, dn}, 64'd0);
    end

    // Reset in the middle of a divide: outputs clear asynchronously, no done follows.
    @(negedge clk);
    A = 32'd100; B = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    check("midreset_zlo",  {32'd0, ZLO}, 64'd0);
    check("midreset_zhi",  {32'd0, ZHI}, 64'd0);
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("midreset_no_done", {63'd0, seen_done}, 64'd0);
    run_div(32'd9, 32'd4, 1'b0, lat, bz, dzv, dn);
    check("post_reset_latency", 64'(lat), 64'd33);
    check("post_reset_zlo", {32'd0, ZLO}, 64'd2);
    check("post_reset_zhi", {32'd0, ZHI}, 64'd1);

    // start held high, operands change every cycle: only IDLE-cycle operands count,
    // and done pulses once every 34 clocks.
    for (int e = 0; e < 102; e++) begin
      @(negedge clk);
      a_hist[e] = 32'd1000 + 32'(e) * 32'd13;
      b_hist[e] = 32'd3 + 32'(e % 5);
      A = a_hist[e]; B = b_hist[e]; sgn = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      check($sformatf("stream_done_e%0d", e), {63'd0, done}, {63'd0, (e % 34 == 33)});
      if (e % 34 == 33) begin
        check($sformatf("stream_zlo_e%0d", e), {32'd0, ZLO}, {32'd0, a_hist[e-33] / b_hist[e-33]});
        check($sformatf("stream_zhi_e%0d", e), {32'd0, ZHI}, {32'd0, a_hist[e-33] % b_hist[e-33]});
      end
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
